// File: rtl/fifo_pkg.sv
// Shared defaults for the SRAM-backed FIFO controller.
// Latency: n/a (constants only).
// Backpressure: n/a.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 8;
  localparam int DEPTH              = 2 ** DEFAULT_ADDR_WIDTH;

endpackage

// File: rtl/fifo_ptr.sv
// Wrap pointer: ADDR_WIDTH address bits plus one wrap bit, with increment and clear.
// Latency: ptr updates on the clock edge after inc/clr.
// Backpressure: none; the caller only raises inc for accepted transfers.
//
// Ports: clk, rst (async active-low), clr (sync clear, wins over inc), inc, ptr.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                inc,
  output logic [ADDR_WIDTH:0] ptr
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + (ADDR_WIDTH+1)'(1);
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller in front of an external dual-address SRAM: pointers, count, flags, SRAM strobes.
// Latency: write captured on the push edge; pop_data valid (pop_valid) 1 cycle after the pop edge.
// Backpressure: push refused while full, pop refused while empty; refusals set sticky error flags.
//
// Ports: clk, rst (async active-low), flush (sync clear), push/push_data, pop,
//        pop_data/pop_valid, full/empty/almost_full/almost_empty, count, overflow/underflow,
//        mem_cs/mem_wr_en/mem_rd_en/mem_waddr/mem_raddr/mem_din to the SRAM, mem_dout from it.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int AF_LEVEL   = 252,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  mem_cs,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(2 ** ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT   = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_CNT   = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic                push_ok;
  logic                pop_ok;
  logic [ADDR_WIDTH:0] wptr;
  logic [ADDR_WIDTH:0] rptr;
  logic [ADDR_WIDTH:0] count_nxt;
  logic                unused_wrap_bits;

  // flush owns the cycle: no transfer is accepted while it is high.
  assign push_ok = push & ~full  & ~flush;
  assign pop_ok  = pop  & ~empty & ~flush;

  // SRAM strobes are gated by rst so an asynchronous reset kills any access in flight.
  assign mem_wr_en = push_ok & rst;
  assign mem_rd_en = pop_ok & rst;
  assign mem_cs    = (push_ok | pop_ok) & rst;
  assign mem_din   = rst ? push_data : '0;
  assign mem_waddr = wptr[ADDR_WIDTH-1:0];
  assign mem_raddr = rptr[ADDR_WIDTH-1:0];
  assign pop_data  = mem_dout;

  // Occupancy is tracked by count; the pointer wrap bits are kept only for debug visibility.
  assign unused_wrap_bits = wptr[ADDR_WIDTH] ^ rptr[ADDR_WIDTH];

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (push_ok),
    .ptr (wptr)
  );

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (pop_ok),
    .ptr (rptr)
  );

  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else if (push_ok && !pop_ok) begin
      count_nxt = count + (ADDR_WIDTH+1)'(1);
    end else if (pop_ok && !push_ok) begin
      count_nxt = count - (ADDR_WIDTH+1)'(1);
    end
  end

  // Flags are registered from the next count so they line up with count itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      pop_valid    <= 1'b0;
    end else begin
      count        <= count_nxt;
      empty        <= (count_nxt == '0);
      full         <= (count_nxt == FULL_CNT);
      almost_empty <= (count_nxt <= AE_CNT);
      almost_full  <= (count_nxt >= AF_CNT);
      pop_valid    <= pop_ok;
      if (flush) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (push && full) begin
          overflow <= 1'b1;
        end
        if (pop && empty) begin
          underflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl with a behavioural SRAM and a queue-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_fifo_ctrl;
  import fifo_pkg::*;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       push;
  logic [7:0] push_data;
  logic       pop;
  logic [7:0] pop_data;
  logic       pop_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [8:0] count;
  logic       overflow;
  logic       underflow;
  logic       mem_cs;
  logic       mem_wr_en;
  logic       mem_rd_en;
  logic [7:0] mem_waddr;
  logic [7:0] mem_raddr;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;

  int errors = 0;
  int checks = 0;

  fifo_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .push         (push),
    .push_data    (push_data),
    .pop          (pop),
    .pop_data     (pop_data),
    .pop_valid    (pop_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .mem_cs       (mem_cs),
    .mem_wr_en    (mem_wr_en),
    .mem_rd_en    (mem_rd_en),
    .mem_waddr    (mem_waddr),
    .mem_raddr    (mem_raddr),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: registered read, write captured on the same edge.
  logic [7:0] sram [0:255];
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_wr_en) sram[mem_waddr] <= mem_din;
      if (mem_rd_en) mem_dout <= sram[mem_raddr];
    end
  end

  // Reference model: the FIFO contents as a queue plus transfer totals.
  logic [7:0] mq[$];
  int         m_wr_total;
  int         m_rd_total;
  bit         m_ovf;
  bit         m_unf;
  bit         m_pv;
  logic [7:0] m_pd;

  task automatic model_reset();
    mq.delete();
    m_wr_total = 0;
    m_rd_total = 0;
    m_ovf = 0;
    m_unf = 0;
    m_pv  = 0;
  endtask

  task automatic drive(input bit p, input bit r, input logic [7:0] d, input bit f);
    push = p;
    pop = r;
    push_data = d;
    flush = f;
  endtask

  // Advance the model by the current inputs, then clock the DUT; returns at edge + 1.
  task automatic step();
    bit w_ok;
    bit r_ok;
    if (flush) begin
      model_reset();
    end else begin
      w_ok = push && (mq.size() < DEPTH);
      r_ok = pop && (mq.size() > 0);
      if (push && mq.size() == DEPTH) m_ovf = 1;
      if (pop && mq.size() == 0) m_unf = 1;
      m_pv = r_ok;
      if (r_ok) begin
        m_pd = mq.pop_front();
        m_rd_total++;
      end
      if (w_ok) begin
        mq.push_back(push_data);
        m_wr_total++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (count !== 9'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae: got %b want 1", almost_empty); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af: got %b want 0", almost_full); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_sticky: got %b%b want 00", overflow, underflow); end
    checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL reset_pop_valid: got %b want 0", pop_valid); end
    checks++; if (mem_cs !== 1'b0) begin errors++; $display("FAIL reset_mem_cs: got %b want 0", mem_cs); end
    #2 rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [7:0] vals [3];
    vals[0] = 8'h0A; vals[1] = 8'h14; vals[2] = 8'h1E;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, vals[i], 0);
      step();
    end
    drive(0, 0, 8'h00, 0);
    checks++; if (count !== 9'd3) begin errors++; $display("FAIL basic_count: got %0d want 3", count); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL basic_empty: got %b want 0", empty); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 8'h00, 0);
      step();
      checks++; if (pop_valid !== 1'b1 || pop_data !== vals[i]) begin
        errors++; $display("FAIL basic_pop%0d: got v=%b d=%h want v=1 d=%h", i, pop_valid, pop_data, vals[i]);
      end
    end
    drive(0, 0, 8'h00, 0);
    step();
    checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL basic_pv_idle: got %b want 0", pop_valid); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 256; i++) begin
      drive(1, 0, 8'(i), 0);
      step();
      if (i == 254) begin
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_early: got %b want 0", full); end
      end
    end
    checks++; if (full !== 1'b1 || count !== 9'd256) begin errors++; $display("FAIL full_set: got full=%b count=%0d want 1/256", full, count); end
    checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL full_af: got %b want 1", almost_full); end
    drive(1, 0, 8'hEE, 0);
    #1;
    checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL full_wr_block: got %b want 0", mem_wr_en); end
    step();
    checks++; if (overflow !== 1'b1 || count !== 9'd256) begin errors++; $display("FAIL full_overflow: got ovf=%b count=%0d want 1/256", overflow, count); end
    for (int i = 0; i < 256; i++) begin
      drive(0, 1, 8'h00, 0);
      step();
      checks++; if (pop_valid !== 1'b1 || pop_data !== 8'(i)) begin
        errors++; $display("FAIL full_drain%0d: got v=%b d=%h want v=1 d=%h", i, pop_valid, pop_data, 8'(i));
      end
    end
    drive(0, 0, 8'h00, 0);
    step();
    checks++; if (empty !== 1'b1 || count !== 9'd0) begin errors++; $display("FAIL full_empty: got empty=%b count=%0d want 1/0", empty, count); end
  endtask

  task automatic test_underflow();
    drive(0, 1, 8'h00, 0);
    #1;
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL unf_rd_block: got %b want 0", mem_rd_en); end
    step();
    checks++; if (pop_valid !== 1'b0 || underflow !== 1'b1) begin errors++; $display("FAIL unf_set: got pv=%b unf=%b want 0/1", pop_valid, underflow); end
    drive(0, 0, 8'h00, 1);
    step();
    drive(0, 0, 8'h00, 0);
    checks++; if (underflow !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL unf_flush: got unf=%b ovf=%b want 0/0", underflow, overflow); end
  endtask

  task automatic test_simul();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 8'($urandom), 0);
      step();
    end
    drive(1, 1, 8'($urandom), 0);
    #1;
    checks++; if (mem_wr_en !== 1'b1 || mem_rd_en !== 1'b1) begin errors++; $display("FAIL simul5_en: got wr=%b rd=%b want 1/1", mem_wr_en, mem_rd_en); end
    step();
    checks++; if (count !== 9'd5 || pop_data !== m_pd) begin errors++; $display("FAIL simul5: got count=%0d d=%h want 5 d=%h", count, pop_data, m_pd); end
    while (mq.size() > 0) begin
      drive(0, 1, 8'h00, 0);
      step();
    end
    drive(1, 1, 8'($urandom), 0);
    #1;
    checks++; if (mem_wr_en !== 1'b1 || mem_rd_en !== 1'b0) begin errors++; $display("FAIL simul0_en: got wr=%b rd=%b want 1/0", mem_wr_en, mem_rd_en); end
    step();
    checks++; if (count !== 9'd1 || pop_valid !== 1'b0) begin errors++; $display("FAIL simul0: got count=%0d pv=%b want 1/0", count, pop_valid); end
    while (mq.size() < DEPTH) begin
      drive(1, 0, 8'($urandom), 0);
      step();
    end
    drive(1, 1, 8'($urandom), 0);
    #1;
    checks++; if (mem_wr_en !== 1'b0 || mem_rd_en !== 1'b1) begin errors++; $display("FAIL simul256_en: got wr=%b rd=%b want 0/1", mem_wr_en, mem_rd_en); end
    step();
    checks++; if (count !== 9'd255 || pop_data !== m_pd) begin errors++; $display("FAIL simul256: got count=%0d d=%h want 255 d=%h", count, pop_data, m_pd); end
    drive(0, 0, 8'h00, 1);
    step();
    drive(0, 0, 8'h00, 0);
  endtask

  task automatic test_wrap();
    int  pushes;
    int  guard;
    bit  p;
    bit  r;
    bit  saw_wrap;
    pushes = 1;
    guard = 0;
    saw_wrap = 0;
    drive(1, 0, 8'($urandom), 0);
    step();
    while (pushes < 600 && guard < 5000) begin
      guard++;
      p = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      if (mq.size() >= 10) p = 0;
      if (mq.size() <= 1 && !p) r = 0;
      drive(p, r, 8'($urandom), 0);
      #1;
      if (p) begin
        if (mem_waddr == 8'h00 && m_wr_total > 0) saw_wrap = 1;
        checks++; if (mem_waddr !== 8'(m_wr_total % 256)) begin errors++; $display("FAIL wrap_waddr: got %0d want %0d", mem_waddr, m_wr_total % 256); end
      end
      if (r) begin
        checks++; if (mem_raddr !== 8'(m_rd_total % 256)) begin errors++; $display("FAIL wrap_raddr: got %0d want %0d", mem_raddr, m_rd_total % 256); end
      end
      step();
      pushes += int'(p);
      checks++; if (count !== 9'(mq.size()) || almost_empty !== (mq.size() <= 4)) begin
        errors++; $display("FAIL wrap_count: got count=%0d ae=%b want %0d/%b", count, almost_empty, mq.size(), (mq.size() <= 4));
      end
      checks++; if (pop_valid !== m_pv || (m_pv && pop_data !== m_pd)) begin
        errors++; $display("FAIL wrap_pop: got v=%b d=%h want v=%b d=%h", pop_valid, pop_data, m_pv, m_pd);
      end
    end
    checks++; if (!saw_wrap || pushes < 600) begin errors++; $display("FAIL wrap_coverage: got wrap=%b pushes=%0d want 1/600", saw_wrap, pushes); end
    drive(0, 0, 8'h00, 1);
    step();
    drive(0, 0, 8'h00, 0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 100; i++) begin
      drive(1, 0, 8'(i), 0);
      step();
    end
    checks++; if (count !== 9'd100) begin errors++; $display("FAIL arst_pre_count: got %0d want 100", count); end
    drive(1, 0, 8'h77, 0);
    #2 rst = 1'b0;
    #1;
    checks++; if (count !== 9'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL arst_count: got count=%0d empty=%b full=%b want 0/1/0", count, empty, full); end
    checks++; if (almost_empty !== 1'b1 || almost_full !== 1'b0 || pop_valid !== 1'b0) begin errors++; $display("FAIL arst_flags: got ae=%b af=%b pv=%b want 1/0/0", almost_empty, almost_full, pop_valid); end
    checks++; if ({mem_cs, mem_wr_en, mem_rd_en} !== 3'b000 || mem_waddr !== 8'h00 || mem_din !== 8'h00) begin
      errors++; $display("FAIL arst_mem: got cs=%b wr=%b rd=%b wa=%h din=%h want all 0", mem_cs, mem_wr_en, mem_rd_en, mem_waddr, mem_din);
    end
    model_reset();
    drive(0, 0, 8'h00, 0);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    drive(1, 0, 8'h55, 0);
    step();
    drive(0, 1, 8'h00, 0);
    step();
    drive(0, 0, 8'h00, 0);
    checks++; if (pop_valid !== 1'b1 || pop_data !== 8'h55) begin errors++; $display("FAIL arst_after: got v=%b d=%h want 1/55", pop_valid, pop_data); end
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 8'h00, 0);
    model_reset();
    test_reset();
    test_basic();
    test_full();
    test_underflow();
    test_simul();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
